// File: rtl/if_id_pkg.sv
// if_id_pkg: shared types and constants for the IF/ID decoupling buffer.
package if_id_pkg;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_4;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_id_entry_mem.sv
// if_id_entry_mem: DEPTH x fetch_entry_t register file, synchronous write, asynchronous read.
module if_id_entry_mem
    import if_id_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         we,
    input  logic [AW-1:0] waddr,
    input  fetch_entry_t wdata,
    input  logic [AW-1:0] raddr,
    output fetch_entry_t rdata
);

    fetch_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_id_buffer.sv
// if_id_buffer: in-order FIFO between fetch and decode with flush, stall and
// misaligned-pc flagging; ready depends only on registered occupancy.
module if_id_buffer
    import if_id_pkg::*;
#(
    parameter  int          DEPTH = 2,
    parameter  logic [31:0] NOP   = NOP_DEFAULT,
    localparam int          AW    = $clog2(DEPTH),
    localparam int          CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_pc,
    input  logic [31:0]   in_pc_4,
    input  logic [31:0]   in_instr,
    input  logic          flush,
    input  logic          id_stall,
    output logic          out_valid,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_pc_4,
    output logic [31:0]   out_instr,
    output logic          out_addr_err,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;
    fetch_entry_t  head;

    assign in_ready  = count_q != FULL;
    assign out_valid = count_q != '0;
    assign count     = count_q;

    always_comb begin
        push     = in_valid & in_ready & ~flush;
        pop      = out_valid & ~id_stall & ~flush;
        wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
        rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
        count_d  = flush ? '0 : count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    if_id_entry_mem #(.DEPTH(DEPTH)) u_mem (
        .clk  (clk),
        .we   (push),
        .waddr(wr_ptr_q),
        .wdata('{pc: in_pc, pc_4: in_pc_4, instr: in_instr}),
        .raddr(rd_ptr_q),
        .rdata(head)
    );

    // Stale entries stay in the array; everything visible is masked by out_valid.
    always_comb begin
        out_pc       = out_valid ? head.pc    : '0;
        out_pc_4     = out_valid ? head.pc_4  : '0;
        out_instr    = out_valid ? head.instr : NOP;
        out_addr_err = out_valid & (head.pc[1:0] != 2'b00);
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// tb_if_id_buffer: scoreboard bench; a queue models buffer contents and every
// cycle's outputs are compared against its head and size.
module tb_if_id_buffer;
    import if_id_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0, flush = 1'b0, id_stall = 1'b0;
    logic [31:0] in_pc = '0, in_pc_4 = '0, in_instr = '0;
    logic        in_ready, out_valid, out_addr_err;
    logic [31:0] out_pc, out_pc_4, out_instr;
    logic [1:0]  count;

    fetch_entry_t sb_q[$];
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    if_id_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_pc_4(in_pc_4), .in_instr(in_instr),
        .flush(flush), .id_stall(id_stall),
        .out_valid(out_valid), .out_pc(out_pc), .out_pc_4(out_pc_4),
        .out_instr(out_instr), .out_addr_err(out_addr_err), .count(count)
    );

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("count", 96'(count), 96'(sb_q.size()));
        chk("in_ready", 96'(in_ready), 96'(sb_q.size() != DEPTH));
        chk("out_valid", 96'(out_valid), 96'(sb_q.size() != 0));
        if (sb_q.size() != 0) begin
            chk("out_pc", 96'(out_pc), 96'(sb_q[0].pc));
            chk("out_pc_4", 96'(out_pc_4), 96'(sb_q[0].pc_4));
            chk("out_instr", 96'(out_instr), 96'(sb_q[0].instr));
            chk("out_addr_err", 96'(out_addr_err), 96'(sb_q[0].pc[1:0] != 2'b00));
        end else begin
            chk("idle_pc", 96'(out_pc), 96'(0));
            chk("idle_pc_4", 96'(out_pc_4), 96'(0));
            chk("idle_instr", 96'(out_instr), 96'(32'h0));
            chk("idle_addr_err", 96'(out_addr_err), 96'(0));
        end
    endtask

    // One cycle: drive on the falling edge, check, then advance the model at the rising edge.
    task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                        input bit stall, input bit fl);
        bit do_push, do_pop;
        fetch_entry_t e;
        @(negedge clk);
        in_valid = v; in_pc = pc; in_pc_4 = pc + 32'd4; in_instr = ins;
        id_stall = stall; flush = fl;
        #1;
        check_outputs();
        do_push = v && sb_q.size() != DEPTH && !fl;
        do_pop  = sb_q.size() != 0 && !stall && !fl;
        e = '{pc: pc, pc_4: pc + 32'd4, instr: ins};
        @(posedge clk);
        if (fl) sb_q.delete();
        else begin
            if (do_pop) void'(sb_q.pop_front());
            if (do_push) sb_q.push_back(e);
        end
    endtask

    initial begin
        #12;
        check_outputs();
        chk("reset_ready", 96'(in_ready), 96'(1));
        @(negedge clk);
        reset = 1'b1;

        // single push, then drained next cycle
        step(1, 32'h0000_0040, 32'h8C22_0004, 0, 0);
        step(0, 32'h0, 32'h0, 0, 0);
        step(0, 32'h0, 32'h0, 0, 0);

        // fill under stall; third is refused until space frees up
        step(1, 32'h0000_0040, 32'h1111_0001, 1, 0);
        step(1, 32'h0000_0044, 32'h1111_0002, 1, 0);
        step(1, 32'h0000_0048, 32'h1111_0003, 1, 0);
        step(1, 32'h0000_0048, 32'h1111_0003, 0, 0);
        step(1, 32'h0000_0048, 32'h1111_0003, 0, 0);
        step(0, 32'h0, 32'h0, 0, 0);
        step(0, 32'h0, 32'h0, 0, 0);

        // flush beats stall and a concurrent push
        step(1, 32'h0000_0100, 32'h2222_0001, 1, 0);
        step(1, 32'h0000_0104, 32'h2222_0002, 1, 0);
        step(1, 32'h0000_0108, 32'h2222_0003, 1, 1);
        step(0, 32'h0, 32'h0, 0, 0);
        step(0, 32'h0, 32'h0, 0, 1);

        // streaming at count 1 wraps the pointers repeatedly
        step(1, 32'h0000_0200, 32'h3333_0000, 0, 0);
        for (int i = 1; i <= 10; i++)
            step(1, 32'h0000_0200 + 32'(i * 4), 32'h3333_0000 + 32'(i), 0, 0);
        step(0, 32'h0, 32'h0, 0, 0);
        step(0, 32'h0, 32'h0, 0, 0);

        // misaligned pc flagged only while it is the head
        step(1, 32'h0000_0042, 32'h4444_0001, 1, 0);
        step(1, 32'h0000_0050, 32'h4444_0002, 1, 0);
        step(0, 32'h0, 32'h0, 0, 0);
        step(0, 32'h0, 32'h0, 0, 0);
        step(0, 32'h0, 32'h0, 0, 0);

        // random traffic
        for (int i = 0; i < 60; i++)
            step($urandom_range(0, 3) != 0, {$urandom_range(0, 255), 2'($urandom_range(0, 3))},
                 $urandom, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);

        // asynchronous reset mid-stream at count 2
        step(1, 32'h0000_0300, 32'h5555_0001, 1, 0);
        step(1, 32'h0000_0304, 32'h5555_0002, 1, 0);
        @(negedge clk);
        in_valid = 1'b0; id_stall = 1'b1; flush = 1'b0;
        #1;
        chk("pre_reset_count", 96'(count), 96'(2));
        #1;
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 96'(out_valid), 96'(0));
        chk("rst_out_instr", 96'(out_instr), 96'(32'h0));
        chk("rst_in_ready", 96'(in_ready), 96'(1));
        chk("rst_count", 96'(count), 96'(0));
        sb_q.delete();
        @(negedge clk);
        reset = 1'b1;
        step(1, 32'h0000_0400, 32'h6666_0001, 0, 0);
        step(0, 32'h0, 32'h0, 0, 0);
        step(0, 32'h0, 32'h0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/if_id_buffer.md
# if_id_buffer

Two-entry decoupling buffer between the instruction-fetch stage and the decode stage of the five-stage pipeline. It captures each fetched `{pc, pc_4, instr}` triple, holds it while decode is stalled by the hazard unit, and presents it to decode in fetch order. Branch redirects and error redirects discard its whole contents. It also flags misaligned fetch addresses.

## Interface
Parameters:
- `DEPTH`, 2: number of entries. Power of two, at least 2.
- `NOP`, 32'h0000_0000: instruction word driven on `out_instr` whenever `out_valid` is 0.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  fetch presents a valid triple this cycle.
- `in_ready`  out  1  buffer can accept; equals `count != DEPTH`.
- `in_pc`  in  32  fetch address of the instruction.
- `in_pc_4`  in  32  link/next-PC value computed by fetch.
- `in_instr`  in  32  instruction word.
- `flush`  in  1  branch taken or error redirect; discard all entries.
- `id_stall`  in  1  decode cannot consume this cycle (load-use hazard).
- `out_valid`  out  1  head entry is valid.
- `out_pc`, `out_pc_4`, `out_instr`  out  32 each  head entry fields.
- `out_addr_err`  out  1  head entry has `pc[1:0] != 0`. Forced to 0 when `out_valid` is 0.
- `count`  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- push = `in_valid & in_ready & ~flush`. The entry is written at `wr_ptr`, and `wr_ptr` increments modulo DEPTH.
- pop = `out_valid & ~id_stall & ~flush`. `rd_ptr` increments modulo DEPTH.
- `count` next value:
  - count + push − pop when flush is 0;
  - 0 when flush is 1.
- Flush:
  - `count`, `wr_ptr` and `rd_ptr` go to 0 at the edge.
  - A push or pop in the same cycle is suppressed.
  - Stored data is not cleared; it is masked by `out_valid`.
- Outputs are a combinational read of the entry at `rd_ptr`, gated by `out_valid = (count != 0)`.
- When `out_valid` is 0:
  - `out_instr` = NOP;
  - `out_pc` and `out_pc_4` = 0;
  - `out_addr_err` = 0.
- There is no fall-through: an entry pushed in cycle N is first visible in cycle N+1.
- `in_ready` depends only on the registered `count`. When the buffer is full, `in_ready` stays 0 even if a pop occurs in that cycle, so there is no combinational ready-from-stall path.
- Push and pop in the same cycle with 0 < count < DEPTH: `count` is unchanged and both pointers advance.
- `out_addr_err` is computed from the stored pc, not from a separately stored flag.

## Timing
- Reset (asynchronous assert, synchronous release): `count` = 0, both pointers = 0. This gives:
  - `out_valid` = 0, `out_instr` = NOP, `out_pc` = 0, `out_pc_4` = 0, `out_addr_err` = 0;
  - `in_ready` = 1.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.
- Latency from push to `out_valid` is 1 cycle.
- Throughput is 1 entry per cycle when `id_stall` is 0.
- Wrap-around: pointers are `$clog2(DEPTH)` bits and wrap naturally. There is no separate full bit; `count` disambiguates full from empty.
- `flush` and `id_stall` both high: flush wins and the buffer empties.
- Flush while empty has no effect beyond holding the pointers at 0.

## Structure
- Shared package `if_id_pkg`:
  - `NOP` default constant;
  - packed typedef `fetch_entry_t` = {pc[31:0], pc_4[31:0], instr[31:0]} (96 bits).
- One sub-module, `if_id_entry_mem`: a DEPTH × `fetch_entry_t` register array with a synchronous write port and an asynchronous read port, no reset on data.
- Pointer, count and handshake logic live in `if_id_buffer`.

## Test plan
- **Reset:** assert reset low mid-stream with count = 2 → outputs immediately show `out_valid` 0, `out_instr` 32'h0, `in_ready` 1, `count` 0.
- **Single push:** push pc 0x0000_0040, pc_4 0x0000_0044, instr 0x8C22_0004 → next cycle `out_valid` 1 with the same three values; with `id_stall` 0 → the following cycle `count` returns to 0.
- **Fill and stall:** hold `id_stall` 1 and push 3 consecutive instructions → first two accepted, `in_ready` 0 on the third, `count` 2. Release the stall → entries come out in order 0x40, 0x44, then the third is accepted.
- **Flush priority:** with count 2, assert `flush`, `id_stall` and `in_valid` together → next cycle `count` 0, `out_valid` 0, and no new entry is stored.
- **Wrap-around:** 10 back-to-back push/pop cycles at count 1 → pointers wrap 4+ times and output order matches input order with no loss.
- **Misalign:** push pc 0x0000_0042 → `out_addr_err` 1 while that entry is the head, and 0 after it is popped.
